// File: rtl/pim_sched_pkg.sv
// Shared types and constants for the PIM instruction scheduler.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pim_sched_pkg;

  localparam int OP_W   = 4;
  localparam int ADDR_W = 6;

  // The only opcode the sequencing controller can execute
  localparam logic [OP_W-1:0] SUPPORTED_OP = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RETIRE
  } state_t;

  // One queued instruction, tagged with the requester that sent it
  typedef struct packed {
    logic              src;
    logic [OP_W-1:0]   op_code;
    logic [ADDR_W-1:0] reg_addr;
  } entry_t;

endpackage

// File: rtl/pim_sched_fifo.sv
// Circular instruction queue with occupancy count, full and empty flags.
// Latency: push visible at the head one cycle later; head is read combinationally.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module pim_sched_fifo
  import pim_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  entry_t                   i_push_dat,
  input  logic                     i_pop,
  output entry_t                   o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  // A pop frees a slot in the same cycle, so a full queue can still accept
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pim_instr_scheduler.sv
// Arbitrates two hosts into a shared queue and issues one instruction at a time to the PIM controller.
// Latency: handshake to issue pulse is 2 cycles when idle; response 1 cycle after done/timeout.
// Backpressure: req ready drops for both hosts while the queue is full.
module pim_instr_scheduler #(
  parameter int         DEPTH        = 4,
  parameter int         TIMEOUT_CYC  = 255,
  parameter logic [3:0] SUPPORTED_OP = pim_sched_pkg::SUPPORTED_OP
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic [3:0]             i_req0_op_code,
  input  logic [5:0]             i_req0_reg_addr,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic [3:0]             i_req1_op_code,
  input  logic [5:0]             i_req1_reg_addr,
  output logic                   o_rsp_valid,
  output logic                   o_rsp_src,
  output logic                   o_rsp_err,
  output logic                   o_ctl_instr_flag,
  output logic [3:0]             o_ctl_op_code,
  output logic [5:0]             o_ctl_reg_addr,
  input  logic                   i_ctl_done,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_fifo_count
);

  import pim_sched_pkg::*;

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic              w_full;
  logic              w_empty;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_dat;
  entry_t            w_head;

  logic              r_rr_last;
  state_t            r_state;
  logic              r_cur_src;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_flag;
  logic              r_rsp_valid;
  logic              r_rsp_src;
  logic              r_rsp_err;
  logic [OP_W-1:0]   r_ctl_op;
  logic [ADDR_W-1:0] r_ctl_addr;

  // Round-robin grant while the queue has room; a tie goes to the host that did not win last
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!w_full) begin
      if (i_req0_valid && i_req1_valid) begin
        w_grant0 = r_rr_last;
        w_grant1 = ~r_rr_last;
      end else begin
        w_grant0 = i_req0_valid;
        w_grant1 = i_req1_valid;
      end
    end
  end

  // Ready is forced low during reset so every output reads zero immediately
  assign o_req0_ready = w_grant0 & i_reset_n;
  assign o_req1_ready = w_grant1 & i_reset_n;
  assign w_push       = w_grant0 | w_grant1;
  assign w_push_dat   = w_grant1 ? {1'b1, i_req1_op_code, i_req1_reg_addr}
                                 : {1'b0, i_req0_op_code, i_req0_reg_addr};
  assign w_pop        = (r_state == S_IDLE) & ~w_empty;

  pim_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (o_fifo_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Remember the last granted host; reset value 1 lets host 0 win the first tie
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rr_last <= 1'b1;
    end else if (w_push) begin
      r_rr_last <= w_grant1;
    end
  end

  // Dispatcher: pop, issue, wait for done or timeout, retire with a tagged response
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= S_IDLE;
      r_cur_src   <= 1'b0;
      r_tmo_cnt   <= '0;
      r_flag      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_src   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ctl_op    <= '0;
      r_ctl_addr  <= '0;
    end else begin
      r_flag      <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_cur_src <= w_head.src;
            if (w_head.op_code == SUPPORTED_OP) begin
              r_flag     <= 1'b1;
              r_ctl_op   <= w_head.op_code;
              r_ctl_addr <= w_head.reg_addr;
              r_state    <= S_ISSUE;
            end else begin
              // Unsupported opcodes never reach the controller
              r_rsp_valid <= 1'b1;
              r_rsp_src   <= w_head.src;
              r_rsp_err   <= 1'b1;
              r_state     <= S_RETIRE;
            end
          end
        end
        S_ISSUE: begin
          r_tmo_cnt <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // op/addr stay put here: the controller samples them a cycle after the flag
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
          if (i_ctl_done || (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
            r_rsp_valid <= 1'b1;
            r_rsp_src   <= r_cur_src;
            r_rsp_err   <= ~i_ctl_done;
            r_ctl_op    <= '0;
            r_ctl_addr  <= '0;
            r_state     <= S_RETIRE;
          end
        end
        S_RETIRE: begin
          r_rsp_src <= 1'b0;
          r_rsp_err <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ctl_instr_flag = r_flag;
  assign o_ctl_op_code    = r_ctl_op;
  assign o_ctl_reg_addr   = r_ctl_addr;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_src        = r_rsp_src;
  assign o_rsp_err        = r_rsp_err;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_pim_instr_scheduler.sv
// Directed bench for pim_instr_scheduler with a scoreboard and controller model.
// Latency: n/a.
// Backpressure: host drivers hold each request until ready.
module tb_pim_instr_scheduler;

  localparam int         TO  = 255;
  localparam logic [3:0] SUP = 4'h0;

  typedef struct packed {
    logic       src;
    logic [3:0] op;
    logic [5:0] addr;
  } tb_ent_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op_code = '0, req1_op_code = '0;
  logic [5:0] req0_reg_addr = '0, req1_reg_addr = '0;
  logic       rsp_valid, rsp_src, rsp_err;
  logic       ctl_instr_flag;
  logic [3:0] ctl_op_code;
  logic [5:0] ctl_reg_addr;
  logic       ctl_done = 1'b0;
  logic       busy;
  logic [2:0] fifo_count;

  logic                  f_push = 1'b0, f_pop = 1'b0;
  pim_sched_pkg::entry_t f_dat = '0;
  pim_sched_pkg::entry_t f_head;
  logic [2:0]            f_count;
  logic                  f_full, f_empty;

  tb_ent_t h0_q[$], h1_q[$], exp_q[$];
  int      grant_log[$];
  int      n_chk = 0, n_pass = 0;
  int      cyc = 0;
  int      ctl_lat = 5;
  int      n_flags = 0, n_rsp = 0;
  int      last_hs_cyc = 0, last_rsp_cyc = 0;
  int      dcnt = 0, cur_lat = 0, iss_cyc = 0;
  bit      inflight = 1'b0;
  logic [9:0] hold_val = '0;
  tb_ent_t mon_e;

  pim_instr_scheduler dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .i_req0_valid     (req0_valid),
    .o_req0_ready     (req0_ready),
    .i_req0_op_code   (req0_op_code),
    .i_req0_reg_addr  (req0_reg_addr),
    .i_req1_valid     (req1_valid),
    .o_req1_ready     (req1_ready),
    .i_req1_op_code   (req1_op_code),
    .i_req1_reg_addr  (req1_reg_addr),
    .o_rsp_valid      (rsp_valid),
    .o_rsp_src        (rsp_src),
    .o_rsp_err        (rsp_err),
    .o_ctl_instr_flag (ctl_instr_flag),
    .o_ctl_op_code    (ctl_op_code),
    .o_ctl_reg_addr   (ctl_reg_addr),
    .i_ctl_done       (ctl_done),
    .o_busy           (busy),
    .o_fifo_count     (fifo_count)
  );

  pim_sched_fifo #(.DEPTH(4)) u_fifo (
    .i_clk      (clk),
    .i_reset_n  (reset_n),
    .i_push     (f_push),
    .i_push_dat (f_dat),
    .i_pop      (f_pop),
    .o_head_dat (f_head),
    .o_count    (f_count),
    .o_full     (f_full),
    .o_empty    (f_empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input bit src, input logic [3:0] op, input logic [5:0] addr);
    tb_ent_t e;
    e.src = src; e.op = op; e.addr = addr;
    if (src) h1_q.push_back(e);
    else     h0_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((h0_q.size() != 0 || h1_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    @(posedge clk);
    check({tag, "_drained"}, 32'(n < 3000), 1);
  endtask

  task automatic wait_flags(input int target, input string tag);
    int n = 0;
    while (n_flags < target && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(n_flags >= target), 1);
  endtask

  // Host drivers: present queue heads on the falling edge, record handshakes
  always @(negedge clk) begin
    req0_valid = reset_n && (h0_q.size() != 0);
    req1_valid = reset_n && (h1_q.size() != 0);
    if (h0_q.size() != 0) begin req0_op_code = h0_q[0].op; req0_reg_addr = h0_q[0].addr; end
    if (h1_q.size() != 0) begin req1_op_code = h1_q[0].op; req1_reg_addr = h1_q[0].addr; end
    #1;
    if (req0_valid && req1_valid) check("ready_onehot", 32'(req0_ready & req1_ready), 0);
    if (req0_valid && req0_ready) begin
      exp_q.push_back(h0_q.pop_front()); grant_log.push_back(0); last_hs_cyc = cyc;
    end
    if (req1_valid && req1_ready) begin
      exp_q.push_back(h1_q.pop_front()); grant_log.push_back(1); last_hs_cyc = cyc;
    end
  end

  // Controller model plus issue/response scoreboard
  always @(negedge clk) begin
    ctl_done = 1'b0;
    if (!reset_n) begin
      dcnt = 0;
      inflight = 1'b0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) ctl_done = 1'b1;
      end
      if (ctl_instr_flag) begin
        n_flags++;
        check("flag_single", 32'(inflight), 0);
        check("flag_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check("iss_supported", 32'(exp_q[0].op), 32'(SUP));
          check("iss_op", 32'(ctl_op_code), 32'(exp_q[0].op));
          check("iss_addr", 32'(ctl_reg_addr), 32'(exp_q[0].addr));
          hold_val = {exp_q[0].op, exp_q[0].addr};
        end
        cur_lat  = ctl_lat;
        iss_cyc  = cyc;
        inflight = 1'b1;
        if (ctl_lat > 0) dcnt = ctl_lat;
      end else if (inflight && !rsp_valid) begin
        check("wait_hold", 32'({ctl_op_code, ctl_reg_addr}), 32'(hold_val));
      end
      if (rsp_valid) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        check("rsp_pending", 32'(exp_q.size() != 0), 1);
        check("rsp_ctl_zero", 32'({ctl_op_code, ctl_reg_addr}), 0);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("rsp_src", 32'(rsp_src), 32'(mon_e.src));
          if (mon_e.op != SUP) begin
            check("rsp_err_badop", 32'(rsp_err), 1);
          end else begin
            check("rsp_err", 32'(rsp_err), 32'(cur_lat == 0 || cur_lat > TO));
            check("rsp_latency", 32'(cyc - iss_cyc),
                  32'((cur_lat == 0 || cur_lat > TO) ? TO + 1 : cur_lat + 1));
          end
        end
        inflight = 1'b0;
      end
    end
  end

  initial begin
    int base;
    int mx;
    int fexp[4];
    fexp = '{2, 3, 4, 9};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({req0_ready, req1_ready, rsp_valid, rsp_src, rsp_err, ctl_instr_flag,
                                ctl_op_code, ctl_reg_addr, busy, fifo_count}), 0);
    check("reset_fifo_empty", 32'(f_empty), 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Queue boundary: fill, push+pop at full, then drain in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f_push = 1'b1;
      f_dat.reg_addr = 6'(i + 1);
    end
    @(negedge clk);
    f_push = 1'b0;
    check("fifo_fill_count", 32'(f_count), 4);
    check("fifo_full", 32'(f_full), 1);
    f_push = 1'b1; f_pop = 1'b1; f_dat.reg_addr = 6'd9;
    @(negedge clk);
    f_push = 1'b0; f_pop = 1'b0;
    check("fifo_pushpop_full_count", 32'(f_count), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fifo_order_%0d", i), 32'(f_head.reg_addr), 32'(fexp[i]));
      f_pop = 1'b1;
      @(negedge clk);
    end
    f_pop = 1'b0;
    check("fifo_empty_after", 32'(f_empty), 1);
    @(posedge clk);

    // Single supported request, done 40 cycles after issue
    ctl_lat = 40;
    send(0, 4'h0, 6'd5);
    drain("single");
    check("single_flags", 32'(n_flags), 1);
    check("single_rsps", 32'(n_rsp), 1);

    // Unsupported opcode from host 1: error response, no issue
    send(1, 4'h3, 6'd7);
    drain("badop");
    check("badop_no_flag", 32'(n_flags), 1);
    check("badop_rsp_timing", 32'(last_rsp_cyc - last_hs_cyc), 2);

    // Contention straight out of reset
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk);
    ctl_lat = 3;
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      send(0, 4'h0, 6'(i));
      send(1, 4'h0, 6'(8 + i));
    end
    mx = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #2;
      if (int'(fifo_count) > mx) mx = int'(fifo_count);
      if (fifo_count == 3'd4) check("full_ready_low", 32'({req0_ready, req1_ready}), 0);
    end
    @(posedge clk);
    drain("contention");
    check("contention_max_count", 32'(mx), 4);
    check("grant_count", 32'(grant_log.size()), 6);
    for (int i = 0; i < grant_log.size() && i < 6; i++)
      check($sformatf("grant_order_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    // Timeout, then the next queued instruction issues normally
    ctl_lat = 0;
    base = n_flags;
    send(0, 4'h0, 6'h21);
    send(1, 4'h0, 6'h22);
    wait_flags(base + 1, "timeout_first_issue");
    @(posedge clk);
    ctl_lat = 7;
    drain("timeout");
    check("timeout_next_issued", 32'(n_flags - base), 2);

    // Done arriving in the very cycle the timeout would fire
    ctl_lat = TO;
    base = n_rsp;
    send(1, 4'h0, 6'h15);
    drain("done_vs_timeout");
    check("done_vs_timeout_rsp", 32'(n_rsp - base), 1);

    // Ten back-to-back instructions wrap the queue pointers
    ctl_lat = 2;
    base = n_rsp;
    for (int i = 0; i < 10; i++) send(0, 4'h0, 6'(32 + i));
    drain("wrap");
    check("wrap_rsps", 32'(n_rsp - base), 10);

    // Reset pulse while an instruction sits in WAIT
    ctl_lat = 0;
    base = n_flags;
    send(0, 4'h0, 6'h3f);
    send(1, 4'h0, 6'h01);
    send(1, 4'h3, 6'h02);
    wait_flags(base + 1, "midwait_issue");
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    h0_q.delete(); h1_q.delete(); exp_q.delete();
    #1;
    check("midwait_reset_outputs", 32'({req0_ready, req1_ready, rsp_valid, rsp_src, rsp_err, ctl_instr_flag,
                                        ctl_op_code, ctl_reg_addr, busy, fifo_count}), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    base = n_rsp;
    repeat (30) @(posedge clk);
    #1;
    check("midwait_no_rsp", 32'(n_rsp - base), 0);
    check("midwait_idle", 32'({busy, fifo_count}), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
